hazard_stall_unit: RTL and testbench

- Companion to the forwarding unit in the 5-stage MIPS pipeline.
- Forwarding resolves the hazards that can be bypassed. This block handles the rest: it stalls PC and IF/ID and injects ID/EX bubbles for hazards that cannot be bypassed in time.
- It flushes IF/ID on taken branches and jumps resolved in ID.
- A small FSM with a stall counter sequences multi-cycle stalls deterministically. It also honours an external memory-busy freeze.

---
 rtl/hazard_stall_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand stall sequencer and IF/ID flush control.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit #(
  parameter int CNT_W = 2
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ID_JumpBranch,
  input  logic [4:0] ID_rsAddr,
  input  logic [4:0] ID_rtAddr,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_Taken,
  input  logic [4:0] EX_wrAddr,
  input  logic       EX_RegWrite,
  input  logic       EX_MemtoReg,
  input  logic [4:0] MEM_wrAddr,
  input  logic       MEM_MemtoReg,
  input  logic       ext_stall,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       PipeFreeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  localparam logic [2:0] JB_BEQ = 3'd1;
  localparam logic [2:0] JB_BNE = 3'd2;
  localparam logic [2:0] JB_JR  = 3'd3;
  localparam logic [2:0] JB_J   = 3'd4;
  localparam logic [2:0] JB_JAL = 3'd7;

  typedef enum logic {RUN, STALL} st_t;

  st_t              st, st_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] need;
  logic             ex_hit, mem_hit;
  logic             bj, cond_br, jump;
  logic             stall;

  function automatic logic hit(input logic [4:0] a,
                               input logic [4:0] rs,
                               input logic [4:0] rt,
                               input logic       use_rs,
                               input logic       use_rt);
    return (a != 5'd0) &&
           ((use_rs && (a == rs)) || (use_rt && (a == rt)));
  endfunction

  assign ex_hit  = hit(EX_wrAddr, ID_rsAddr, ID_rtAddr,
                       ID_UseRs, ID_UseRt);
  assign mem_hit = hit(MEM_wrAddr, ID_rsAddr, ID_rtAddr,
                       ID_UseRs, ID_UseRt);

  assign cond_br = (ID_JumpBranch == JB_BEQ) ||
                   (ID_JumpBranch == JB_BNE);
  assign bj      = cond_br || (ID_JumpBranch == JB_JR);
  assign jump    = (ID_JumpBranch == JB_J)  ||
                   (ID_JumpBranch == JB_JAL) ||
                   (ID_JumpBranch == JB_JR);

  // BJ resolves in ID, so it needs operands one stage earlier than ALU ops
  always_comb begin
    need = '0;
    if (EX_MemtoReg && ex_hit && bj)
      need = CNT_W'(2);
    else if (EX_MemtoReg && ex_hit)
      need = CNT_W'(1);
    else if (EX_RegWrite && !EX_MemtoReg && ex_hit && bj)
      need = CNT_W'(1);
    else if (MEM_MemtoReg && mem_hit && bj)
      need = CNT_W'(1);
  end

  always_comb begin
    st_n       = st;
    rem_n      = rem;
    stall      = 1'b0;
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PipeFreeze = 1'b0;
    if (rst) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (ext_stall) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      PipeFreeze = 1'b1;
    end else begin
      unique case (st)
        RUN: begin
          if (need != '0) begin
            stall = 1'b1;
            rem_n = need - CNT_W'(1);
            st_n  = (need > CNT_W'(1)) ? STALL : RUN;
          end else begin
            IFID_Flush = jump || (cond_br && ID_Taken);
          end
        end
        STALL: begin
          stall = 1'b1;
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1))
            st_n = RUN;
        end
        default: st_n = RUN;
      endcase
      if (stall) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= RUN;
      rem <= '0;
    end else begin
      st  <= st_n;
      rem <= rem_n;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (!ext_stall) begin
      if (stall)
        perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (IFID_Flush)
        perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit.
// Outputs packed as {PC_Write,IFID_Write,IFID_Flush,IDEX_Flush,PipeFreeze}.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ID_JumpBranch;
  logic [4:0] ID_rsAddr, ID_rtAddr;
  logic       ID_UseRs, ID_UseRt, ID_Taken;
  logic [4:0] EX_wrAddr;
  logic       EX_RegWrite, EX_MemtoReg;
  logic [4:0] MEM_wrAddr;
  logic       MEM_MemtoReg;
  logic       ext_stall;
  logic       PC_Write, IFID_Write, IFID_Flush;
  logic       IDEX_Flush, PipeFreeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_STL = 5'b00010;
  localparam logic [4:0] O_FLS = 5'b11100;
  localparam logic [4:0] O_FRZ = 5'b00001;
  localparam logic [4:0] O_RST = 5'b00110;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .ID_JumpBranch(ID_JumpBranch),
    .ID_rsAddr(ID_rsAddr), .ID_rtAddr(ID_rtAddr),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Taken(ID_Taken),
    .EX_wrAddr(EX_wrAddr), .EX_RegWrite(EX_RegWrite),
    .EX_MemtoReg(EX_MemtoReg),
    .MEM_wrAddr(MEM_wrAddr), .MEM_MemtoReg(MEM_MemtoReg),
    .ext_stall(ext_stall),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .PipeFreeze(PipeFreeze)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, PC_Write, IFID_Write, IFID_Flush,
            IDEX_Flush, PipeFreeze};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ID_JumpBranch = 3'd0;
    ID_rsAddr = 5'd0; ID_rtAddr = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Taken = 1'b0;
    EX_wrAddr = 5'd0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0;
    MEM_wrAddr = 5'd0; MEM_MemtoReg = 1'b0;
    ext_stall = 1'b0;
  endtask

  task automatic ex_lw(input logic [4:0] r);
    EX_wrAddr = r; EX_RegWrite = 1'b1; EX_MemtoReg = 1'b1;
  endtask

  task automatic ex_clr();
    EX_wrAddr = 5'd0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0;
  endtask

  task automatic chk_st(input string tag,
                        input int s, input int r);
    check({tag, "_st"}, 32'(dut.st), 32'(s));
    check({tag, "_rem"}, 32'(dut.rem), 32'(r));
  endtask

  task automatic lw_beq(input logic [2:0] jb);
    clr();
    ex_lw(5'd9);
    ID_JumpBranch = jb;
    ID_rsAddr = 5'd3; ID_UseRs = 1'b1;
    ID_rtAddr = 5'd9; ID_UseRt = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #1;
    check("rst_out", outs(), O_RST);
    tick();
    rst = 1'b0;
    #1;
    check("idle", outs(), O_RUN);
    chk_st("idle", 0, 0);

    // load-use: one bubble, FSM stays RUN
    ex_lw(5'd8);
    ID_rsAddr = 5'd8; ID_UseRs = 1'b1;
    #1 check("lu_stall", outs(), O_STL);
    tick();
    chk_st("lu_after", 0, 0);
    ex_clr();
    #1 check("lu_go", outs(), O_RUN);

    // lw -> beq taken: two stalls, flush only after
    lw_beq(3'd1);
    ID_Taken = 1'b1;
    #1 check("lb_s1", outs(), O_STL);
    tick();
    chk_st("lb_s1", 1, 1);
    check("lb_s2", outs(), O_STL);
    tick();
    chk_st("lb_s2", 0, 0);
    ex_clr();
    #1 check("lb_flush", outs(), O_FLS);

    // ALU -> jr: one stall then flush
    clr();
    EX_wrAddr = 5'd31; EX_RegWrite = 1'b1;
    ID_JumpBranch = 3'd3; ID_rsAddr = 5'd31; ID_UseRs = 1'b1;
    #1 check("jr_stall", outs(), O_STL);
    tick();
    chk_st("jr_after", 0, 0);
    ex_clr();
    #1 check("jr_flush", outs(), O_FLS);

    // MEM lw feeding bne stalls; feeding an ALU op does not
    clr();
    MEM_wrAddr = 5'd12; MEM_MemtoReg = 1'b1;
    ID_JumpBranch = 3'd2; ID_rtAddr = 5'd12; ID_UseRt = 1'b1;
    #1 check("mem_bne", outs(), O_STL);
    tick();
    ID_JumpBranch = 3'd0;
    #1 check("mem_alu", outs(), O_RUN);

    // ALU result into non-branch is forwarded: no stall
    clr();
    EX_wrAddr = 5'd4; EX_RegWrite = 1'b1;
    ID_rsAddr = 5'd4; ID_UseRs = 1'b1;
    #1 check("alu_alu", outs(), O_RUN);
    ID_JumpBranch = 3'd1;
    #1 check("beq_nt", outs(), O_STL);
    tick();

    // unconditional jumps flush; not-taken branch does not
    clr();
    ID_JumpBranch = 3'd4;
    #1 check("j_flush", outs(), O_FLS);
    ID_JumpBranch = 3'd7;
    #1 check("jal_flush", outs(), O_FLS);
    ID_JumpBranch = 3'd2;
    #1 check("bne_nt", outs(), O_RUN);

    // register 0 and unused operand never match
    clr();
    ex_lw(5'd0);
    ID_rsAddr = 5'd0; ID_UseRs = 1'b1;
    #1 check("r0", outs(), O_RUN);
    tick();
    check("r0_next", outs(), O_RUN);
    ex_lw(5'd5);
    ID_rsAddr = 5'd6; ID_rtAddr = 5'd5; ID_UseRt = 1'b0;
    #1 check("unused_rt", outs(), O_RUN);
    tick();
    check("unused_next", outs(), O_RUN);

    // freeze in the middle of a 2-cycle stall
    lw_beq(3'd2);
    #1 check("fz_s1", outs(), O_STL);
    tick();
    chk_st("fz_s1", 1, 1);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("fz_out", outs(), O_FRZ);
      tick();
      chk_st("fz_hold", 1, 1);
    end
    ext_stall = 1'b0;
    #1 check("fz_s2", outs(), O_STL);
    tick();
    chk_st("fz_done", 0, 0);
    ex_clr();
    #1 check("fz_go", outs(), O_RUN);

    // reset while in STALL
    lw_beq(3'd1);
    #1 check("rs_s1", outs(), O_STL);
    tick();
    chk_st("rs_s1", 1, 1);
    rst = 1'b1;
    ext_stall = 1'b1;
    #1 check("rs_out", outs(), O_RST);
    tick();
    rst = 1'b0;
    clr();
    #1 check("rs_go", outs(), O_RUN);
    chk_st("rs_go", 0, 0);
`ifdef HAZARD_PERF_EN
    check("perf_stall0", perf_stall_cnt, 32'd0);
    check("perf_flush0", perf_flush_cnt, 32'd0);
    ID_JumpBranch = 3'd4;
    tick();
    ex_lw(5'd7);
    ID_JumpBranch = 3'd0;
    ID_rsAddr = 5'd7; ID_UseRs = 1'b1;
    tick();
    check("perf_stall1", perf_stall_cnt, 32'd1);
    check("perf_flush1", perf_flush_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
